// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and width helpers for the multi-slave APB master
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // Select field is at least one bit wide so a single-slave bus still has an index.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - slave index field to one-hot psel plus out-of-range flag
module apb_addr_decoder #(
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = 2
) (
    input  logic [SEL_W-1:0]      i_addr_hi,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic                  o_decode_err
);

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            o_sel[i] = (int'(i_addr_hi) == i);
        end
    end

    assign o_decode_err = (int'(i_addr_hi) >= NUM_SLAVES);

endmodule

// File: rtl/apb_master_mslv.sv
// rtl/apb_master_mslv.sv - single-outstanding APB master driving NUM_SLAVES slaves on a shared bus
module apb_master_mslv
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             preset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             rsp_timeout,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    localparam int SEL_W  = sel_width(NUM_SLAVES);
    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int TMR_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    apb_state_e            r_state;
    logic [NUM_SLAVES-1:0] r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_W-1:0]     r_pstrb;
    logic [TMR_W-1:0]      r_timer;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_timeout;

    logic [NUM_SLAVES-1:0] w_sel;
    logic                  w_dec_err;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_ready;
    logic                  w_slverr;
    logic                  w_tmo;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_W      (SEL_W)
    ) u_dec (
        .i_addr_hi    (req_addr[ADDR_WIDTH-1 -: SEL_W]),
        .o_sel        (w_sel),
        .o_decode_err (w_dec_err)
    );

    // The latched one-hot select doubles as the return-path mux, so unselected slaves are never looked at.
    always_comb begin
        w_rdata  = '0;
        w_ready  = 1'b0;
        w_slverr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_psel[i]) begin
                w_rdata  = w_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_ready  = w_ready | pready[i];
                w_slverr = w_slverr | pslverr[i];
            end
        end
    end

    assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state   <= IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_pwdata  <= '0;
            r_pstrb   <= '0;
            r_timer   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_dec_err) begin
                            r_state <= RESP;
                            r_err   <= 1'b1;
                        end else begin
                            r_state  <= SETUP;
                            r_psel   <= w_sel;
                            r_paddr  <= req_addr;
                            r_pwrite <= req_write;
                            r_pwdata <= req_write ? req_wdata : '0;
                            r_pstrb  <= req_write ? req_strb : '0;
                            r_timer  <= '0;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_ready || w_tmo) begin
                        r_state   <= RESP;
                        r_err     <= w_ready ? w_slverr : 1'b1;
                        r_timeout <= !w_ready;
                        r_rdata   <= (w_ready && !r_pwrite && !w_slverr) ? w_rdata : '0;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_paddr   <= '0;
                        r_pwrite  <= 1'b0;
                        r_pwdata  <= '0;
                        r_pstrb   <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        r_rdata   <= '0;
                        r_err     <= 1'b0;
                        r_timeout <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == IDLE);
    assign rsp_valid   = (r_state == RESP);
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign rsp_timeout = r_timeout;
    assign paddr       = r_paddr;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;

endmodule

// File: tb/tb_apb_master_mslv.sv
// tb/tb_apb_master_mslv.sv - directed and randomized checks of apb_master_mslv against a transaction-level model
module tb_apb_master_mslv;

    localparam int TMO = 16;

    logic         pclk = 1'b0;
    logic         preset_n;
    logic         req_valid, req_ready, req_write;
    logic [7:0]   req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_strb;
    logic         rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0]  rsp_rdata;
    logic [7:0]   paddr;
    logic [3:0]   psel;
    logic         penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [127:0] prdata;
    logic [3:0]   pready, pslverr;

    logic         b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err, b_rsp_timeout;
    logic [31:0]  b_rsp_rdata, b_pwdata;
    logic [7:0]   b_req_addr, b_paddr;
    logic [2:0]   b_psel, b_pready, b_pslverr;
    logic         b_penable, b_pwrite;
    logic [3:0]   b_pstrb;
    logic [95:0]  b_prdata;

    int n_pass = 0;
    int n_total = 0;

    always #5 pclk = ~pclk;

    apb_master_mslv #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(TMO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master_mslv #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_SLAVES(3), .TIMEOUT_CYCLES(TMO)) dut_b (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(1'b0),
        .req_addr(b_req_addr), .req_wdata(32'h0), .req_strb(4'h0),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .rsp_timeout(b_rsp_timeout),
        .paddr(b_paddr), .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite),
        .pwdata(b_pwdata), .pstrb(b_pstrb), .prdata(b_prdata), .pready(b_pready), .pslverr(b_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // One command through the master; expectations come from the transaction rules, not from the FSM.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int waits, input logic serr,
                           input int hold, input logic [31:0] rd_val);
        int          idx, exp_lat, lat;
        logic        dec, tmo, e_err;
        logic [31:0] e_rdata;
        logic [3:0]  e_sel;
        idx     = int'(addr[7:6]);
        dec     = (idx >= 4);
        tmo     = !dec && (waits >= TMO);
        e_err   = dec || tmo || serr;
        exp_lat = dec ? 1 : (tmo ? 2 + TMO : 3 + waits);
        e_rdata = (!wr && !e_err) ? rd_val : 32'h0;
        e_sel   = dec ? 4'b0 : 4'(1 << idx);
        for (int i = 0; i < 4; i++) prdata[i*32 +: 32] = (i == idx) ? rd_val : $urandom;
        req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        pready = '0; pslverr = '0;
        chk("req_ready_idle", req_ready, 1'b1);
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            tick();
            if (c == 1) begin
                req_valid = 1'b0; req_write = 1'($urandom);
                req_addr = 8'($urandom); req_wdata = $urandom; req_strb = 4'($urandom);
            end
            if (rsp_valid) lat = c;
            else if (!dec) begin
                chk("psel", psel, e_sel);
                chk("penable", penable, c >= 2);
                chk("paddr", paddr, addr);
                chk("pwrite", pwrite, wr);
                chk("pwdata", pwdata, wr ? wd : 32'h0);
                chk("pstrb", pstrb, wr ? st : 4'h0);
            end
            pready  = 4'($urandom);
            pslverr = 4'($urandom);
            pready[idx]  = (c >= 2) && (c - 2 >= waits);
            pslverr[idx] = serr;
        end
        chk("latency", lat, exp_lat);
        chk("psel_in_resp", psel, 4'h0);
        chk("penable_in_resp", penable, 1'b0);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_timeout", rsp_timeout, tmo);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("rsp_held", rsp_valid, 1'b1);
            chk("req_ready_in_resp", req_ready, 1'b0);
        end
        if (hold > 0) chk("rsp_rdata_held", {rsp_rdata, 31'b0, rsp_err}, {e_rdata, 31'b0, e_err});
        rsp_ready = 1'b1;
        tick();
        chk("rsp_valid_after", rsp_valid, 1'b0);
        chk("req_ready_after", req_ready, 1'b1);
        chk("rsp_fields_clear", {rsp_rdata, rsp_err, rsp_timeout}, 34'h0);
        rsp_ready = 1'b0;
        pready = '0; pslverr = '0;
    endtask

    initial begin
        preset_n = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0;
        rsp_ready = 0; prdata = '0; pready = '0; pslverr = '0;
        b_req_valid = 0; b_req_addr = 0; b_rsp_ready = 0; b_prdata = '0; b_pready = '0; b_pslverr = '0;
        #2 preset_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 35'h0);
        chk("rst_bus", {psel, penable, pwrite, paddr, pwdata, pstrb}, 50'h0);
        chk("rst_b", {b_req_ready, b_psel, b_rsp_valid}, 5'b10000);
        repeat (2) @(posedge pclk);
        @(negedge pclk) preset_n = 1'b1;
        tick();

        run_txn(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0, $urandom);
        run_txn(1'b0, 8'h84, 32'h0, 4'h0, 3, 1'b0, 1, 32'h12345678);
        run_txn(1'b1, 8'h40, 32'hA5A5A5A5, 4'h3, 0, 1'b1, 5, $urandom);
        run_txn(1'b0, 8'hC0, 32'h0, 4'h0, 1000, 1'b0, 1, $urandom);
        run_txn(1'b0, 8'h44, 32'h0, 4'h0, TMO - 1, 1'b0, 0, 32'hCAFEF00D);

        b_req_addr = 8'hC0; b_req_valid = 1'b1;
        tick();
        chk("b_rsp_valid_t1", b_rsp_valid, 1'b1);
        chk("b_psel_none", {b_psel, b_penable}, 4'h0);
        chk("b_err", {b_rsp_err, b_rsp_timeout}, 2'b10);
        chk("b_req_ready_busy", b_req_ready, 1'b0);
        b_req_valid = 1'b0; b_rsp_ready = 1'b1;
        tick();
        chk("b_idle_again", {b_rsp_valid, b_req_ready}, 2'b01);
        b_rsp_ready = 1'b0;

        req_write = 1'b1; req_addr = 8'h50; req_wdata = 32'h11223344; req_strb = 4'hF; req_valid = 1'b1;
        pready = '0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid_access", {psel, penable}, 5'b00101);
        preset_n = 1'b0;
        #1;
        chk("rst_mid_bus", {psel, penable, paddr}, 13'h0);
        chk("rst_mid_rsp", {rsp_valid, req_ready}, 2'b01);
        @(negedge pclk) preset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_rsp_after_rst", {rsp_valid, psel}, 5'h0);
        end
        run_txn(1'b1, 8'h50, 32'h55AA00FF, 4'h5, 1, 1'b0, 0, $urandom);

        for (int n = 0; n < 24; n++) begin
            run_txn(1'($urandom), 8'($urandom), $urandom, 4'($urandom),
                    ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4)),
                    ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
